// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC units: word format, gain compensation,
// arctangent table and the folded-engine state encoding.
package cordic_pkg;
  localparam int WORD_LENGTH  = 21;
  localparam int FRAC_BITS    = 19;
  localparam int N_ITERATIONS = 17;
  localparam int GUARD_BITS   = 2;
  localparam int CNT_W        = 5;

  // 1/K for the accumulated micro-rotation gain, in 2.19 format
  localparam logic [WORD_LENGTH-1:0] K_INV = 21'b00_1001101101110100111;

  // round(atan(2^-i) * 2^19)
  localparam logic [WORD_LENGTH-1:0] ATAN_TABLE [0:N_ITERATIONS-1] = '{
    21'd411775, 21'd243085, 21'd128439, 21'd65198, 21'd32725, 21'd16379,
    21'd8191,   21'd4096,   21'd2048,   21'd1024,  21'd512,   21'd256,
    21'd128,    21'd64,     21'd32,     21'd16,    21'd8
  };

  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;
endpackage

// File: rtl/cordic_atan_lut.sv
// Micro-rotation angle lookup: iteration index to alpha, combinational.
// Indices past the table return zero.
module cordic_atan_lut
  import cordic_pkg::*;
(
  input  logic [CNT_W-1:0]       idx,
  output logic [WORD_LENGTH-1:0] alpha
);
  always_comb begin
    alpha = '0;
    if (32'(idx) < N_ITERATIONS) alpha = ATAN_TABLE[idx];
  end
endmodule

// File: rtl/cordic_vector_folded.sv
// Folded vectoring CORDIC: (x, y) -> atan2(y, x) and gain-compensated magnitude,
// one shared micro-rotation per cycle, valid/ready on both sides.
module cordic_vector_folded
  import cordic_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic signed [WORD_LENGTH-1:0] x_i,
  input  logic signed [WORD_LENGTH-1:0] y_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic signed [WORD_LENGTH-1:0] angle_o,
  output logic signed [WORD_LENGTH-1:0] mag_o,
  output logic                          err_o
);
  localparam int XW = WORD_LENGTH + GUARD_BITS;
  localparam int PW = XW + WORD_LENGTH;
  localparam logic signed [PW-1:0] MAG_MAX = PW'(2**(WORD_LENGTH-1) - 1);
  localparam logic signed [PW-1:0] MAG_MIN = ~MAG_MAX;

  state_t                        state;
  logic [CNT_W-1:0]              cnt;
  logic signed [XW-1:0]          x, y;
  logic signed [WORD_LENGTH-1:0] z;

  logic [WORD_LENGTH-1:0]        alpha;
  logic signed [WORD_LENGTH-1:0] alpha_s, z_nxt, mag_sat;
  logic signed [XW-1:0]          x_sh, y_sh, x_nxt, y_nxt;
  logic signed [PW-1:0]          prod, prod_sh;
  logic                          neg_x, zero_in;

  cordic_atan_lut u_lut (
    .idx   (cnt),
    .alpha (alpha)
  );

  assign alpha_s = $signed(alpha);
  assign neg_x   = x_i[WORD_LENGTH-1];
  assign zero_in = (x_i == '0) && (y_i == '0);

  // Drive y toward zero; both updates use the pre-update x and y.
  always_comb begin
    x_sh = x >>> cnt;
    y_sh = y >>> cnt;
    if (y[XW-1]) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - alpha_s;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + alpha_s;
    end
  end

  always_comb begin
    prod    = $signed({{(PW-XW){x[XW-1]}}, x}) *
              $signed({{(PW-WORD_LENGTH){1'b0}}, K_INV});
    prod_sh = prod >>> FRAC_BITS;
    if (prod_sh > MAG_MAX)
      mag_sat = MAG_MAX[WORD_LENGTH-1:0];
    else if (prod_sh < MAG_MIN)
      mag_sat = MAG_MIN[WORD_LENGTH-1:0];
    else
      mag_sat = prod_sh[WORD_LENGTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      angle_o <= '0;
      mag_o   <= '0;
      err_o   <= 1'b0;
      cnt     <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            x       <= {{GUARD_BITS{x_i[WORD_LENGTH-1]}}, x_i};
            y       <= {{GUARD_BITS{y_i[WORD_LENGTH-1]}}, y_i};
            z       <= '0;
            cnt     <= '0;
            ready_o <= 1'b0;
            if (neg_x || zero_in) begin
              angle_o <= '0;
              mag_o   <= '0;
              err_o   <= neg_x;
              state   <= DONE;
            end else begin
              state <= ITER;
            end
          end
        end
        ITER: begin
          x   <= x_nxt;
          y   <= y_nxt;
          z   <= z_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(N_ITERATIONS - 1)) state <= SCALE;
        end
        SCALE: begin
          mag_o   <= mag_sat;
          angle_o <= z;
          err_o   <= 1'b0;
          valid_o <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          // Early-exit results arrive with valid_o low and raise it here.
          if (!valid_o) begin
            valid_o <= 1'b1;
          end else if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_vector_folded.sv
// Directed-vector bench for the folded vectoring CORDIC.
`timescale 1ns/1ps
module tb_cordic_vector_folded;
  localparam int W = 21;

  logic                clk = 1'b0;
  logic                rst;
  logic                valid_i, ready_o, valid_o, ready_i, err_o;
  logic signed [W-1:0] x_i, y_i, angle_o, mag_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cordic_vector_folded dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .x_i     (x_i),
    .y_i     (y_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .angle_o (angle_o),
    .mag_o   (mag_o),
    .err_o   (err_o)
  );

  typedef struct {
    string name;
    int    x;
    int    y;
    int    angle;
    int    tol_a;
    int    mag;
    int    tol_m;
    int    err;
    int    lat;
  } vec_t;

  vec_t vecs[7];

  function automatic void check(input string name, input int act, input int exp, input int tol);
    n_total++;
    if (act >= exp - tol && act <= exp + tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
  endfunction

  // Presents one operand, returns edges from the accept edge to valid_o high.
  task automatic run_op(input int x, input int y, output int lat);
    @(negedge clk);
    x_i     = x[W-1:0];
    y_i     = y[W-1:0];
    valid_i = 1'b1;
    check("ready_before_accept", int'(ready_o), 1, 0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_valid_drop"}, int'(valid_o), 0, 0);
    check({name, "_ready_back"}, int'(ready_o), 1, 0);
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;
    int a0, m0, e0;

    vecs[0] = '{"q1_diag",   262144,  262144,  411775, 16,  370728, 24, 0, 18};
    vecs[1] = '{"x_axis",    524288,  0,       0,      16,  524288, 24, 0, 18};
    vecs[2] = '{"y_axis",    0,       524288,  823550, 16,  524288, 24, 0, 18};
    vecs[3] = '{"saturate",  786432,  786432,  411775, 16,  1048575, 0, 0, 18};
    vecs[4] = '{"neg_x",     -262144, 0,       0,      0,   0,       0, 1, 1};
    vecs[5] = '{"origin",    0,       0,       0,      0,   0,       0, 0, 1};
    vecs[6] = '{"q4_diag",   262144,  -262144, -411775, 16, 370728, 24, 0, 18};

    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; x_i = '0; y_i = '0;
    #12;
    check("rst_ready", int'(ready_o), 1, 0);
    check("rst_valid", int'(valid_o), 0, 0);
    check("rst_angle", int'(angle_o), 0, 0);
    check("rst_mag",   int'(mag_o),   0, 0);
    check("rst_err",   int'(err_o),   0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].x, vecs[i].y, lat);
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat, 0);
      check({vecs[i].name, "_angle"}, int'(angle_o), vecs[i].angle, vecs[i].tol_a);
      check({vecs[i].name, "_mag"},   int'(mag_o),   vecs[i].mag,   vecs[i].tol_m);
      check({vecs[i].name, "_err"},   int'(err_o),   vecs[i].err,   0);
      consume(vecs[i].name);
    end

    // Backpressure: results hold and new operands are ignored.
    run_op(262144, 262144, lat);
    check("hold_latency", lat, 18, 0);
    a0 = int'(angle_o); m0 = int'(mag_o); e0 = int'(err_o);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      valid_i = c[0];
      x_i = 21'sd100000 + 21'(c);
      y_i = -21'sd50000;
      @(posedge clk);
      #1;
      if (int'(angle_o) != a0 || int'(mag_o) != m0 || int'(err_o) != e0 ||
          valid_o !== 1'b1 || ready_o !== 1'b0) bad++;
    end
    check("hold_stable_cycles_bad", bad, 0, 0);
    check("hold_angle", a0, 411775, 16);
    @(negedge clk);
    valid_i = 1'b0;
    consume("hold");

    // Asynchronous reset while the counter is at 7.
    run_op(524288, 0, lat);
    consume("pre_reset");
    @(negedge clk);
    x_i = 21'sd262144; y_i = 21'sd262144; valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", int'(valid_o), 0, 0);
    check("midrst_ready", int'(ready_o), 1, 0);
    check("midrst_mag",   int'(mag_o),   0, 0);
    check("midrst_angle", int'(angle_o), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (valid_o) bad++;
    end
    check("midrst_no_stale_valid", bad, 0, 0);
    run_op(262144, 262144, lat);
    check("post_rst_latency", lat, 18, 0);
    check("post_rst_angle", int'(angle_o), 411775, 16);
    check("post_rst_mag",   int'(mag_o),   370728, 24);
    check("post_rst_err",   int'(err_o),   0, 0);
    consume("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
